// File: rtl/alu_unit.sv
// Integer execution unit feeding the ALU CDB port: single-cycle RV32I ops, plus an
// optional 32-iteration multiply/divide path enabled by defining ALU_MULDIV_EN.
module alu_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 4,
    parameter int OP_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear,
    input  logic              ALU_valid,
    input  logic [OP_W-1:0]   ALU_op,
    input  logic [XLEN-1:0]   ALU_reg1,
    input  logic [XLEN-1:0]   ALU_reg2,
    input  logic [XLEN-1:0]   ALU_imm,
    input  logic [ADDR_W-1:0] ALU_pc,
    input  logic [TAG_W-1:0]  ALU_reg_des_rob,
    output logic              ALU_busy,
    output logic              ALU_cdb_valid,
    output logic [TAG_W-1:0]  ALU_cdb_tag,
    output logic [XLEN-1:0]   ALU_cdb_data
);
    localparam int SH_W = $clog2(XLEN);

    localparam logic [OP_W-1:0] OP_LUI   = 6'd1,  OP_AUIPC = 6'd2,  OP_ADD   = 6'd3;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'd4,  OP_SUB   = 6'd5,  OP_AND   = 6'd6;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'd7,  OP_OR    = 6'd8,  OP_ORI   = 6'd9;
    localparam logic [OP_W-1:0] OP_XOR   = 6'd10, OP_XORI  = 6'd11, OP_SLT   = 6'd12;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'd13, OP_SLTU  = 6'd14, OP_SLTIU = 6'd15;
    localparam logic [OP_W-1:0] OP_SLL   = 6'd16, OP_SLLI  = 6'd17, OP_SRL   = 6'd18;
    localparam logic [OP_W-1:0] OP_SRLI  = 6'd19, OP_SRA   = 6'd20, OP_SRAI  = 6'd21;

    logic [SH_W-1:0] shamt_r;
    logic [SH_W-1:0] shamt_i;
    logic [XLEN-1:0] alu_result;
    logic            accept;

    assign shamt_r = ALU_reg2[SH_W-1:0];
    assign shamt_i = ALU_imm[SH_W-1:0];

`ifdef ALU_MULDIV_EN
    localparam logic [OP_W-1:0] OP_MUL   = 6'd22, OP_MULH  = 6'd23, OP_MULHSU = 6'd24;
    localparam logic [OP_W-1:0] OP_MULHU = 6'd25, OP_DIV   = 6'd26, OP_DIVU   = 6'd27;
    localparam logic [OP_W-1:0] OP_REM   = 6'd28, OP_REMU  = 6'd29;
    localparam logic [SH_W-1:0] LAST     = SH_W'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
    state_t state_reg, state_next;

    logic                 iterative, is_mul_op, a_signed, b_signed, a_neg, b_neg;
    logic                 div_zero, div_ovf;
    logic [XLEN-1:0]      a_abs, b_abs;
    logic [SH_W-1:0]      count_reg;
    logic [OP_W-1:0]      mop_reg;
    logic [TAG_W-1:0]     op_tag_reg;
    logic                 neg_reg, rem_neg_reg;
    logic [2*XLEN-1:0]    mul_acc_reg, mul_cand_reg, mul_acc_next, product;
    logic [XLEN-1:0]      mul_plier_reg;
    logic [XLEN-1:0]      div_rem_reg, div_quo_reg, div_dsor_reg;
    logic [XLEN:0]        div_shift;
    logic                 div_ge;
    logic [XLEN-1:0]      div_diff, div_rem_next, div_quo_next, quo_final, rem_final;
    logic [XLEN-1:0]      iter_result;

    assign ALU_busy  = (state_reg != IDLE);
    assign accept    = ALU_valid && rdy && !clear && (state_reg == IDLE);
    assign is_mul_op = (ALU_op >= OP_MUL) && (ALU_op <= OP_MULHU);
    assign a_signed  = (ALU_op == OP_MULH) || (ALU_op == OP_MULHSU) || (ALU_op == OP_DIV) || (ALU_op == OP_REM);
    assign b_signed  = (ALU_op == OP_MULH) || (ALU_op == OP_DIV) || (ALU_op == OP_REM);
    assign a_neg     = a_signed && ALU_reg1[XLEN-1];
    assign b_neg     = b_signed && ALU_reg2[XLEN-1];
    assign a_abs     = a_neg ? -ALU_reg1 : ALU_reg1;
    assign b_abs     = b_neg ? -ALU_reg2 : ALU_reg2;
    assign div_zero  = (ALU_reg2 == '0);
    // Signed overflow (most-negative / -1) is the only case the iterative path cannot represent.
    assign div_ovf   = ((ALU_op == OP_DIV) || (ALU_op == OP_REM)) &&
                       (ALU_reg1 == {1'b1, {(XLEN-1){1'b0}}}) && (ALU_reg2 == '1);

    assign mul_acc_next = mul_plier_reg[0] ? mul_acc_reg + mul_cand_reg : mul_acc_reg;
    assign product      = neg_reg ? -mul_acc_next : mul_acc_next;
    assign div_shift    = {div_rem_reg, div_quo_reg[XLEN-1]};
    assign div_ge       = div_shift >= {1'b0, div_dsor_reg};
    assign div_diff     = div_shift[XLEN-1:0] - div_dsor_reg;
    assign div_rem_next = div_ge ? div_diff : div_shift[XLEN-1:0];
    assign div_quo_next = {div_quo_reg[XLEN-2:0], div_ge};
    assign quo_final    = neg_reg ? -div_quo_next : div_quo_next;
    assign rem_final    = rem_neg_reg ? -div_rem_next : div_rem_next;

    always_comb begin
        case (mop_reg)
            OP_MUL:                       iter_result = product[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: iter_result = product[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              iter_result = quo_final;
            default:                      iter_result = rem_final;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:     if (accept && iterative) state_next = is_mul_op ? MUL : DIV;
                MUL, DIV: if (count_reg == LAST) state_next = IDLE;
                default:  state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      state_reg <= IDLE;
        else if (rdy) state_reg <= state_next;
    end
`else
    assign ALU_busy = 1'b0;
    assign accept   = ALU_valid && rdy && !clear;
`endif

    always_comb begin
        alu_result = '0;
`ifdef ALU_MULDIV_EN
        iterative  = 1'b0;
`endif
        case (ALU_op)
            OP_LUI:   alu_result = ALU_imm;
            OP_AUIPC: alu_result = XLEN'(ALU_pc) + ALU_imm;
            OP_ADD:   alu_result = ALU_reg1 + ALU_reg2;
            OP_ADDI:  alu_result = ALU_reg1 + ALU_imm;
            OP_SUB:   alu_result = ALU_reg1 - ALU_reg2;
            OP_AND:   alu_result = ALU_reg1 & ALU_reg2;
            OP_ANDI:  alu_result = ALU_reg1 & ALU_imm;
            OP_OR:    alu_result = ALU_reg1 | ALU_reg2;
            OP_ORI:   alu_result = ALU_reg1 | ALU_imm;
            OP_XOR:   alu_result = ALU_reg1 ^ ALU_reg2;
            OP_XORI:  alu_result = ALU_reg1 ^ ALU_imm;
            OP_SLT:   alu_result = XLEN'($signed(ALU_reg1) < $signed(ALU_reg2));
            OP_SLTI:  alu_result = XLEN'($signed(ALU_reg1) < $signed(ALU_imm));
            OP_SLTU:  alu_result = XLEN'(ALU_reg1 < ALU_reg2);
            OP_SLTIU: alu_result = XLEN'(ALU_reg1 < ALU_imm);
            OP_SLL:   alu_result = ALU_reg1 << shamt_r;
            OP_SLLI:  alu_result = ALU_reg1 << shamt_i;
            OP_SRL:   alu_result = ALU_reg1 >> shamt_r;
            OP_SRLI:  alu_result = ALU_reg1 >> shamt_i;
            OP_SRA:   alu_result = $signed(ALU_reg1) >>> shamt_r;
            OP_SRAI:  alu_result = $signed(ALU_reg1) >>> shamt_i;
`ifdef ALU_MULDIV_EN
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: iterative = 1'b1;
            OP_DIV, OP_DIVU: begin
                if (div_zero)     alu_result = '1;
                else if (div_ovf) alu_result = ALU_reg1;
                else              iterative  = 1'b1;
            end
            OP_REM, OP_REMU: begin
                if (div_zero)     alu_result = ALU_reg1;
                else if (!div_ovf) iterative = 1'b1;
            end
`endif
            default:  alu_result = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ALU_cdb_valid <= 1'b0;
            ALU_cdb_tag   <= '0;
            ALU_cdb_data  <= '0;
            count_reg     <= '0;
            mop_reg       <= '0;
            op_tag_reg    <= '0;
            neg_reg       <= 1'b0;
            rem_neg_reg   <= 1'b0;
            mul_acc_reg   <= '0;
            mul_cand_reg  <= '0;
            mul_plier_reg <= '0;
            div_rem_reg   <= '0;
            div_quo_reg   <= '0;
            div_dsor_reg  <= '0;
        end else if (rdy) begin
            ALU_cdb_valid <= 1'b0;
            if (clear) begin
                count_reg <= '0;
            end else if (state_reg == IDLE) begin
                if (accept && !iterative) begin
                    ALU_cdb_valid <= 1'b1;
                    ALU_cdb_tag   <= ALU_reg_des_rob;
                    ALU_cdb_data  <= alu_result;
                end else if (accept) begin
                    count_reg     <= '0;
                    mop_reg       <= ALU_op;
                    op_tag_reg    <= ALU_reg_des_rob;
                    neg_reg       <= a_neg ^ b_neg;
                    rem_neg_reg   <= a_neg;
                    mul_acc_reg   <= '0;
                    mul_cand_reg  <= {{XLEN{1'b0}}, a_abs};
                    mul_plier_reg <= b_abs;
                    div_rem_reg   <= '0;
                    div_quo_reg   <= a_abs;
                    div_dsor_reg  <= b_abs;
                end
            end else begin
                if (state_reg == MUL) begin
                    mul_acc_reg   <= mul_acc_next;
                    mul_cand_reg  <= mul_cand_reg << 1;
                    mul_plier_reg <= mul_plier_reg >> 1;
                end else begin
                    div_rem_reg <= div_rem_next;
                    div_quo_reg <= div_quo_next;
                end
                count_reg <= count_reg + 1'b1;
                if (count_reg == LAST) begin
                    ALU_cdb_valid <= 1'b1;
                    ALU_cdb_tag   <= op_tag_reg;
                    ALU_cdb_data  <= iter_result;
                    count_reg     <= '0;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ALU_cdb_valid <= 1'b0;
            ALU_cdb_tag   <= '0;
            ALU_cdb_data  <= '0;
        end else if (rdy) begin
            ALU_cdb_valid <= accept;
            if (accept) begin
                ALU_cdb_tag  <= ALU_reg_des_rob;
                ALU_cdb_data <= alu_result;
            end
        end
    end
`endif
endmodule

// File: tb/tb_alu_unit.sv
// Directed self-checking bench for alu_unit; the multiply/divide section follows ALU_MULDIV_EN.
module tb_alu_unit;
    localparam logic [5:0] OP_LUI  = 6'd1,  OP_AUIPC = 6'd2,  OP_ADD   = 6'd3,  OP_ADDI  = 6'd4;
    localparam logic [5:0] OP_SUB  = 6'd5,  OP_AND   = 6'd6,  OP_ANDI  = 6'd7,  OP_OR    = 6'd8;
    localparam logic [5:0] OP_ORI  = 6'd9,  OP_XOR   = 6'd10, OP_XORI  = 6'd11, OP_SLT   = 6'd12;
    localparam logic [5:0] OP_SLTI = 6'd13, OP_SLTU  = 6'd14, OP_SLTIU = 6'd15, OP_SLL   = 6'd16;
    localparam logic [5:0] OP_SLLI = 6'd17, OP_SRL   = 6'd18, OP_SRLI  = 6'd19, OP_SRA   = 6'd20;
    localparam logic [5:0] OP_SRAI = 6'd21, OP_MUL   = 6'd22, OP_MULH  = 6'd23, OP_MULHSU = 6'd24;
    localparam logic [5:0] OP_MULHU = 6'd25, OP_DIV  = 6'd26, OP_DIVU  = 6'd27, OP_REM   = 6'd28;
    localparam logic [5:0] OP_REMU = 6'd29;

    logic        clk = 1'b0;
    logic        rst, rdy, clear, ALU_valid;
    logic [5:0]  ALU_op;
    logic [31:0] ALU_reg1, ALU_reg2, ALU_imm, ALU_pc;
    logic [3:0]  ALU_reg_des_rob;
    logic        ALU_busy, ALU_cdb_valid;
    logic [3:0]  ALU_cdb_tag;
    logic [31:0] ALU_cdb_data;

    int vectors     = 0;
    int miscompares = 0;

    alu_unit dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .ALU_valid(ALU_valid), .ALU_op(ALU_op), .ALU_reg1(ALU_reg1), .ALU_reg2(ALU_reg2),
        .ALU_imm(ALU_imm), .ALU_pc(ALU_pc), .ALU_reg_des_rob(ALU_reg_des_rob),
        .ALU_busy(ALU_busy), .ALU_cdb_valid(ALU_cdb_valid),
        .ALU_cdb_tag(ALU_cdb_tag), .ALU_cdb_data(ALU_cdb_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Issuing while busy is a reservation-station protocol violation.
    always @(negedge clk) begin
        if (rst === 1'b0 && ALU_busy === 1'b1 && ALU_valid === 1'b1) begin
            miscompares++;
            $error("FAIL protocol: ALU_valid observed 1 while busy, required 0");
        end
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
        end
        $display("vector %0d %s: observed 0x%08h expected 0x%08h", vectors, name, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] im, input logic [31:0] p, input logic [3:0] t);
        ALU_op = op; ALU_reg1 = r1; ALU_reg2 = r2; ALU_imm = im; ALU_pc = p;
        ALU_reg_des_rob = t; ALU_valid = 1'b1;
        step();
        ALU_valid = 1'b0;
    endtask

    task automatic single(input string name, input logic [5:0] op, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [31:0] im, input logic [31:0] p,
                          input logic [3:0] t, input logic [31:0] exp);
        issue(op, r1, r2, im, p, t);
        check({name, "_valid"}, 32'(ALU_cdb_valid), 32'd1);
        check({name, "_tag"}, 32'(ALU_cdb_tag), 32'(t));
        check({name, "_data"}, ALU_cdb_data, exp);
    endtask

`ifdef ALU_MULDIV_EN
    task automatic run_iter(input string name, input logic [5:0] op, input logic [31:0] r1,
                            input logic [31:0] r2, input logic [3:0] t, input logic [31:0] exp);
        int bad = 0;
        issue(op, r1, r2, 32'd0, 32'd0, t);
        ALU_reg1 = 32'hDEADBEEF; ALU_reg2 = 32'h0; ALU_op = OP_ADD; ALU_reg_des_rob = 4'hF;
        for (int i = 0; i < 32; i++) begin
            if (ALU_busy !== 1'b1 || ALU_cdb_valid !== 1'b0) bad++;
            step();
        end
        check({name, "_busy_window"}, 32'(bad), 32'd0);
        check({name, "_valid"}, 32'(ALU_cdb_valid), 32'd1);
        check({name, "_tag"}, 32'(ALU_cdb_tag), 32'(t));
        check({name, "_data"}, ALU_cdb_data, exp);
        check({name, "_busy_done"}, 32'(ALU_busy), 32'd0);
    endtask
`endif

    initial begin
        int bad;
        rst = 1'b1; rdy = 1'b1; clear = 1'b0; ALU_valid = 1'b0; ALU_op = '0;
        ALU_reg1 = '0; ALU_reg2 = '0; ALU_imm = '0; ALU_pc = '0; ALU_reg_des_rob = '0;
        #12;
        check("reset_valid", 32'(ALU_cdb_valid), 32'd0);
        check("reset_tag", 32'(ALU_cdb_tag), 32'd0);
        check("reset_data", ALU_cdb_data, 32'd0);
        check("reset_busy", 32'(ALU_busy), 32'd0);
        step();
        rst = 1'b0;
        step();

        single("add_wrap", OP_ADD, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h0, 4'd5, 32'h80000000);
        step();
        check("add_pulse_end", 32'(ALU_cdb_valid), 32'd0);

        single("sra_b2b", OP_SRA, 32'hF0000000, 32'h24, 32'h0, 32'h0, 4'd1, 32'hFF000000);
        single("sltu_b2b", OP_SLTU, 32'h1, 32'hFFFFFFFF, 32'h0, 32'h0, 4'd2, 32'h1);
        single("auipc", OP_AUIPC, 32'h0, 32'h0, 32'hFFFFF000, 32'h1000, 4'd3, 32'h0);
        single("lui", OP_LUI, 32'h55, 32'h66, 32'h12345000, 32'h0, 4'd4, 32'h12345000);
        single("sub", OP_SUB, 32'h5, 32'h7, 32'h0, 32'h0, 4'd6, 32'hFFFFFFFE);
        single("and", OP_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0, 32'h0, 4'd7, 32'h00F000F0);
        single("andi", OP_ANDI, 32'h1234, 32'h0, 32'hFF, 32'h0, 4'd8, 32'h34);
        single("or", OP_OR, 32'h1, 32'h2, 32'h0, 32'h0, 4'd9, 32'h3);
        single("ori", OP_ORI, 32'hF000, 32'h0, 32'hF, 32'h0, 4'd10, 32'hF00F);
        single("xor", OP_XOR, 32'hFF, 32'h0F, 32'h0, 32'h0, 4'd11, 32'hF0);
        single("xori", OP_XORI, 32'hFFFF0000, 32'h0, 32'hFFFFFFFF, 32'h0, 4'd12, 32'h0000FFFF);
        single("addi", OP_ADDI, 32'hFFFFFFFF, 32'h100, 32'h1, 32'h0, 4'd13, 32'h0);
        single("slt_neg", OP_SLT, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 4'd14, 32'h1);
        single("sltu_big", OP_SLTU, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 4'd15, 32'h0);
        single("slti", OP_SLTI, 32'h5, 32'h0, 32'hFFFFFFFD, 32'h0, 4'd1, 32'h0);
        single("sltiu", OP_SLTIU, 32'h5, 32'h0, 32'hFFFFFFFD, 32'h0, 4'd2, 32'h1);
        single("sll_mask", OP_SLL, 32'h1, 32'h21, 32'h0, 32'h0, 4'd3, 32'h2);
        single("slli", OP_SLLI, 32'h3, 32'h0, 32'h4, 32'h0, 4'd4, 32'h30);
        single("srl", OP_SRL, 32'h80000000, 32'h1F, 32'h0, 32'h0, 4'd5, 32'h1);
        single("srli", OP_SRLI, 32'h80000000, 32'h0, 32'h24, 32'h0, 4'd6, 32'h08000000);
        single("srai", OP_SRAI, 32'h80000000, 32'h0, 32'h4, 32'h0, 4'd7, 32'hF8000000);
        single("unknown", 6'd63, 32'h5, 32'h6, 32'h7, 32'h8, 4'hA, 32'h0);

        // rdy low freezes the output pulse and ignores the presented op
        single("rdy_pre", OP_ADD, 32'h2, 32'h3, 32'h0, 32'h0, 4'd3, 32'h5);
        rdy = 1'b0;
        ALU_op = OP_ADD; ALU_reg1 = 32'hA; ALU_reg2 = 32'hA; ALU_reg_des_rob = 4'd4; ALU_valid = 1'b1;
        step();
        check("rdy_hold_valid", 32'(ALU_cdb_valid), 32'd1);
        check("rdy_hold_tag", 32'(ALU_cdb_tag), 32'd3);
        step();
        check("rdy_hold_data", ALU_cdb_data, 32'h5);
        ALU_valid = 1'b0; rdy = 1'b1;
        step();
        check("rdy_release_valid", 32'(ALU_cdb_valid), 32'd0);

        // clear discards the op presented on the same edge
        single("clr_pre", OP_ADD, 32'h1, 32'h1, 32'h0, 32'h0, 4'd2, 32'h2);
        clear = 1'b1;
        issue(OP_ADD, 32'h4, 32'h4, 32'h0, 32'h0, 4'd9);
        clear = 1'b0;
        check("clear_drop_valid", 32'(ALU_cdb_valid), 32'd0);

        // asynchronous reset takes effect without a clock edge
        single("arst_pre", OP_ADD, 32'h10, 32'h1, 32'h0, 32'h0, 4'd6, 32'h11);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(ALU_cdb_valid), 32'd0);
        check("arst_data", ALU_cdb_data, 32'd0);
        check("arst_tag", 32'(ALU_cdb_tag), 32'd0);
        step();
        rst = 1'b0;
        step();

`ifdef ALU_MULDIV_EN
        run_iter("mulh", OP_MULH, 32'hFFFFFFFE, 32'h3, 4'd9, 32'hFFFFFFFF);
        run_iter("div", OP_DIV, 32'h7, 32'hFFFFFFFE, 4'd1, 32'hFFFFFFFD);
        run_iter("rem", OP_REM, 32'h7, 32'hFFFFFFFE, 4'd2, 32'h1);
        run_iter("mul", OP_MUL, 32'h12345678, 32'h10, 4'd3, 32'h23456780);
        run_iter("mulhu", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd4, 32'hFFFFFFFE);
        run_iter("mulhsu", OP_MULHSU, 32'hFFFFFFFF, 32'h2, 4'd5, 32'hFFFFFFFF);
        run_iter("divu", OP_DIVU, 32'd100, 32'd7, 4'd6, 32'd14);
        run_iter("remu", OP_REMU, 32'd100, 32'd7, 4'd7, 32'd2);
        run_iter("rem_negdvd", OP_REM, 32'hFFFFFFF9, 32'h2, 4'd8, 32'hFFFFFFFF);

        single("divu_zero", OP_DIVU, 32'h55, 32'h0, 32'h0, 32'h0, 4'd10, 32'hFFFFFFFF);
        check("divu_zero_busy", 32'(ALU_busy), 32'd0);
        single("remu_zero", OP_REMU, 32'h55, 32'h0, 32'h0, 32'h0, 4'd11, 32'h55);
        single("div_zero", OP_DIV, 32'h80000001, 32'h0, 32'h0, 32'h0, 4'd12, 32'hFFFFFFFF);
        single("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0, 4'd13, 32'h80000000);
        check("div_ovf_busy", 32'(ALU_busy), 32'd0);
        single("rem_ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0, 4'd14, 32'h0);

        // clear in the tenth cycle of a divide cancels it
        issue(OP_DIV, 32'd100, 32'd7, 32'h0, 32'h0, 4'd2);
        for (int i = 0; i < 9; i++) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_div_busy", 32'(ALU_busy), 32'd0);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (ALU_cdb_valid !== 1'b0) bad++;
            step();
        end
        check("clear_div_no_bcast", 32'(bad), 32'd0);
        single("after_clear", OP_ADD, 32'h20, 32'h1, 32'h0, 32'h0, 4'd5, 32'h21);

        // asynchronous reset in the middle of a multiply
        issue(OP_MUL, 32'h3, 32'h4, 32'h0, 32'h0, 4'd7);
        for (int i = 0; i < 5; i++) step();
        check("mid_mul_busy", 32'(ALU_busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_mul_busy", 32'(ALU_busy), 32'd0);
        check("arst_mul_data", ALU_cdb_data, 32'd0);
        check("arst_mul_tag", 32'(ALU_cdb_tag), 32'd0);
        step();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (ALU_cdb_valid !== 1'b0 || ALU_busy !== 1'b0) bad++;
            step();
        end
        check("arst_mul_no_bcast", 32'(bad), 32'd0);
`else
        single("mul_unknown", OP_MUL, 32'h5, 32'h6, 32'h0, 32'h0, 4'd6, 32'h0);
        check("mul_unknown_busy", 32'(ALU_busy), 32'd0);
        single("div_unknown", OP_DIV, 32'h9, 32'h3, 32'h0, 32'h0, 4'd7, 32'h0);
        single("remu_unknown", OP_REMU, 32'h9, 32'h0, 32'h0, 32'h0, 4'd8, 32'h0);
        check("remu_unknown_busy", 32'(ALU_busy), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_unit.md
# alu_unit

Execution stage directly downstream of the ALU reservation station. Takes one ready operation per cycle (opcode, two operand values, immediate, PC, destination ROB tag), computes the integer result and broadcasts it on the ALU CDB port to the reservation stations, LSB and ROB. RV32I ops complete in one cycle. An optional iterative multiply/divide path takes 32 cycles and back-pressures the reservation station through a busy flag.

## Interface
- XLEN, 32, operand/result width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- rdy  in  1  global ready; low freezes all state
- clear  in  1  synchronous flush on misprediction
- ALU_valid  in  1  issue strobe from reservation station
- ALU_op  in  OPBus  operation code (shared define header encodings)
- ALU_reg1, ALU_reg2  in  XLEN  rs1/rs2 values
- ALU_imm  in  XLEN  sign-extended immediate
- ALU_pc  in  AddressBus  instruction PC
- ALU_reg_des_rob  in  TagBus  destination ROB tag
- ALU_busy  out  1  high while iterative op in flight; RS must not issue
- ALU_cdb_valid  out  1  result valid, one-cycle pulse per op
- ALU_cdb_tag  out  TagBus  ROB tag of result
- ALU_cdb_data  out  XLEN  result value

## Operation
- Reset: ALU_cdb_valid 0, ALU_cdb_tag 0, ALU_cdb_data 0, ALU_busy 0, FSM IDLE, counter 0.
- FSM states: IDLE, MUL, DIV. IDLE + accepted M-op -> MUL/DIV; 32nd iteration -> IDLE; clear or rst -> IDLE from any state.
- Accept = ALU_valid && rdy && !clear && state==IDLE. ALU_valid while busy is dropped (protocol violation, bench asserts it never happens).
- Single-cycle ops: LUI = imm; AUIPC = pc+imm; ADD/ADDI, SUB, AND/ANDI, OR/ORI, XOR/XORI wrap mod 2^32; SLT/SLTI signed, SLTU/SLTIU unsigned, result 0/1; SLL/SRL/SRA use rs2[4:0], immediate forms use imm[4:0]; SRA/SRAI arithmetic.
- Unknown opcode: result 0, still broadcast with its tag (ROB never stalls on a tag).
- MUL path: shift-add over 64-bit product, signs corrected per MUL/MULH/MULHSU/MULHU; MUL returns low word, others high word.
- DIV path: restoring divide on absolute values, quotient/remainder signs fixed at end (remainder takes dividend sign).
- Divide special cases resolved at acceptance with 1-cycle latency, no busy: divisor 0 -> DIV/DIVU = 0xFFFFFFFF, REM/REMU = dividend; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
- Tag, op and sign info latched at acceptance; inputs may change afterwards.

## Timing
- Single-cycle op accepted at edge N: ALU_cdb_valid high for cycle after N only, data/tag valid same cycle. Back-to-back issue every cycle gives back-to-back broadcasts.
- Iterative op accepted at edge N: ALU_busy high after N; result and ALU_cdb_valid after edge N+32; ALU_busy low after N+32; next issue earliest at edge N+33. ALU_cdb_valid low during cycles N+1..N+32.
- ALU_busy is registered (state != IDLE), no combinational path from inputs.
- No cycle produces two results; ALU_cdb_valid deasserts the cycle after a pulse unless a new result is written.
- clear at edge N: FSM -> IDLE, counter 0, ALU_cdb_valid 0 after N; op presented at N discarded.
- rst asserted mid-iteration: all outputs to reset values immediately, no broadcast.
- rdy low: counter, FSM and CDB outputs hold values (pulse stretched; consumers are gated by rdy too).

## Configuration
- ALU_MULDIV_EN defined: FSM, MUL/DIV datapaths, special-case logic and ALU_busy as above.
- Not defined: no FSM or counter; M-ext opcodes treated as unknown (result 0, 1-cycle latency); ALU_busy tied 0.

## Test plan
- ADD reg1=0x7FFFFFFF reg2=1 tag 5 -> after 1 cycle cdb_valid=1, tag 5, data 0x80000000; next cycle cdb_valid=0.
- SRA reg1=0xF0000000 reg2=0x24 then SLTU reg1=1 reg2=0xFFFFFFFF back-to-back -> 0xFF000000 then 1 on consecutive cycles.
- AUIPC pc=0x1000 imm=0xFFFFF000 -> 0x00000000; LUI imm=0x12345000 -> 0x12345000.
- (MULDIV) MULH 0xFFFFFFFE x 3 tag 9 -> busy for 32 cycles, then cdb data 0xFFFFFFFF tag 9; DIV 7 / -2 -> 0xFFFFFFFD, REM 7 % -2 -> 1.
- (MULDIV) DIVU x/0 and DIV 0x80000000/-1 -> 0xFFFFFFFF and 0x80000000 after 1 cycle, busy never asserted.
- (MULDIV) clear at cycle 10 of a DIV -> busy low and no broadcast after; async rst mid-MUL -> outputs zero before next edge.
